// File: rtl/muldiv_pkg.sv
// Shared opcode encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    sh       = {acc, 1'b0};
    // A negative trial is flagged by bit WIDTH; the shifted remainder is always below 2*divisor.
    trial    = sh[2*WIDTH:WIDTH] - {1'b0, divisor};
    acc_next = acc;
    if (op == OP_MUL) begin
      if (acc[0]) begin
        acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end else begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
      end else begin
        acc_next = sh[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide with valid/ready handshakes, one bit per clock.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] step_acc;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .operand (opd_q),
    .divisor (opd_q),
    .acc_next(step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d  = op;
          dbz_d = 1'b0;
          cnt_d = CW'(WIDTH);
          state_d = RUN;
          if (op == OP_DIV) begin
            opd_d = b;
            acc_d = {{WIDTH{1'b0}}, a};
            if (b == '0) begin
              // Remainder is the dividend, quotient zero, no iterations.
              acc_d   = {a, {WIDTH{1'b0}}};
              dbz_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            // Multiplier sits in the low half and is consumed as the product shifts in.
            opd_d = a;
            acc_d = {{WIDTH{1'b0}}, b};
          end
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      opd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign result      = acc_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=4 and WIDTH=2 with hand-computed expectations.
module tb_muldiv_seq;

  logic clk;
  logic rst_n;

  logic       in_valid4, in_ready4, op4, out_valid4, out_ready4, dbz4;
  logic [3:0] a4, b4;
  logic [7:0] result4;

  logic       in_valid2, in_ready2, op2, out_valid2, out_ready2, dbz2;
  logic [1:0] a2, b2;
  logic [3:0] result2;

  int n_cmp;
  int n_fail;

  muldiv_seq #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .op         (op4),
    .a          (a4),
    .b          (b4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .result     (result4),
    .div_by_zero(dbz4)
  );

  muldiv_seq #(.WIDTH(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .op         (op2),
    .a          (a2),
    .b          (b2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .result     (result2),
    .div_by_zero(dbz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, then count edges (accept edge included) until out_valid rises.
  task automatic run4(input logic o, input logic [3:0] x, input logic [3:0] y, output int cyc);
    op4 = o; a4 = x; b4 = y; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 1;
    while (!out_valid4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run2(input logic o, input logic [1:0] x, input logic [1:0] y, output int cyc);
    op2 = o; a2 = x; b2 = y; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cyc = 1;
    while (!out_valid2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic ack4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic ack2();
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready4);
    end
    n_cmp++;
    if (out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4);
    end
    n_cmp++;
    if (result4 !== 8'h00) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00", result4);
    end
    n_cmp++;
    if (dbz4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dbz: got %b expected 0", dbz4);
    end
  endtask

  task automatic test_mul();
    int cyc;
    run4(1'b0, 4'd13, 4'd11, cyc);
    n_cmp++;
    if (cyc !== 5) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected 5", cyc);
    end
    n_cmp++;
    if (result4 !== 8'h8F) begin
      n_fail++; $display("FAIL mul_13x11: got %h expected 8f", result4);
    end
    n_cmp++;
    if (dbz4 !== 1'b0) begin
      n_fail++; $display("FAIL mul_dbz: got %b expected 0", dbz4);
    end
    ack4();
    n_cmp++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_exit: got valid=%b ready=%b expected valid=0 ready=1",
               out_valid4, in_ready4);
    end
  endtask

  task automatic test_div();
    int cyc;
    run4(1'b1, 4'd14, 4'd3, cyc);
    n_cmp++;
    if (cyc !== 5) begin
      n_fail++; $display("FAIL div_latency: got %0d expected 5", cyc);
    end
    n_cmp++;
    if (result4 !== 8'h24) begin
      n_fail++; $display("FAIL div_14_3: got %h expected 24", result4);
    end
    ack4();
    run4(1'b1, 4'd15, 4'd15, cyc);
    n_cmp++;
    if (result4 !== 8'h01) begin
      n_fail++; $display("FAIL div_15_15: got %h expected 01", result4);
    end
    ack4();
  endtask

  task automatic test_div_zero();
    int cyc;
    run4(1'b1, 4'd9, 4'd0, cyc);
    n_cmp++;
    if (cyc !== 1) begin
      n_fail++; $display("FAIL dz_latency: got %0d expected 1", cyc);
    end
    n_cmp++;
    if (result4 !== 8'h90) begin
      n_fail++; $display("FAIL dz_result: got %h expected 90", result4);
    end
    n_cmp++;
    if (dbz4 !== 1'b1) begin
      n_fail++; $display("FAIL dz_flag: got %b expected 1", dbz4);
    end
    ack4();
    n_cmp++;
    if (dbz4 !== 1'b1) begin
      n_fail++; $display("FAIL dz_flag_held: got %b expected 1", dbz4);
    end
    run4(1'b0, 4'd15, 4'd15, cyc);
    n_cmp++;
    if (result4 !== 8'hE1) begin
      n_fail++; $display("FAIL dz_next_mul: got %h expected e1", result4);
    end
    n_cmp++;
    if (dbz4 !== 1'b0) begin
      n_fail++; $display("FAIL dz_flag_clear: got %b expected 0", dbz4);
    end
    ack4();
  endtask

  task automatic test_backpressure();
    int cyc;
    run4(1'b0, 4'd5, 4'd6, cyc);
    for (int i = 0; i < 6; i++) begin
      a4 = 4'(i * 3); b4 = 4'(15 - i); op4 = i[0]; in_valid4 = i[0];
      @(posedge clk); #1;
      n_cmp++;
      if (result4 !== 8'h1E || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got res=%h ready=%b valid=%b expected res=1e ready=0 valid=1",
                 i, result4, in_ready4, out_valid4);
      end
    end
    in_valid4 = 1'b0;
    ack4();
    n_cmp++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_exit: got ready=%b valid=%b expected ready=1 valid=0",
               in_ready4, out_valid4);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    op4 = 1'b0; a4 = 4'd7; b4 = 4'd7; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (out_valid4 !== 1'b0 || result4 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b res=%h expected valid=0 res=00", out_valid4, result4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready4 !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready4);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid4 !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_resume_%0d: got %b expected 0", i, out_valid4);
      end
    end
    run4(1'b0, 4'd3, 4'd3, cyc);
    n_cmp++;
    if (result4 !== 8'h09) begin
      n_fail++; $display("FAIL rst_next_mul: got %h expected 09", result4);
    end
    ack4();
  endtask

  task automatic test_width2();
    int cyc;
    run2(1'b0, 2'd3, 2'd3, cyc);
    n_cmp++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL w2_latency: got %0d expected 3", cyc);
    end
    n_cmp++;
    if (result2 !== 4'h9) begin
      n_fail++; $display("FAIL w2_mul_3x3: got %h expected 9", result2);
    end
    ack2();
    run2(1'b1, 2'd3, 2'd2, cyc);
    n_cmp++;
    if (result2 !== 4'h5) begin
      n_fail++; $display("FAIL w2_div_3_2: got %h expected 5", result2);
    end
    ack2();
    run2(1'b1, 2'd2, 2'd0, cyc);
    n_cmp++;
    if (result2 !== 4'h8 || dbz2 !== 1'b1) begin
      n_fail++;
      $display("FAIL w2_div_zero: got res=%h dbz=%b expected res=8 dbz=1", result2, dbz2);
    end
    ack2();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b0;
    in_valid2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_width2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide unit: shift-add multiplication, and restoring division as its inverse.
- Serves as the multi-cycle companion to the combinational 2-bit ALU datapath.
- Accepts one operation through a valid/ready input handshake, iterates one bit per clock, and presents the result through a valid/ready output handshake.
- Parameterised width so the same block covers the 2-bit datapath and wider variants.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- op  input  1  0 = multiply, 1 = divide.
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  multiply: full product. Divide: {remainder, quotient}, with quotient in result[WIDTH-1:0].
- div_by_zero  output  1  set with a divide result whose b was 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, all internal registers 0.
  - in_ready=1 after reset release; out_valid=0, result=0, div_by_zero=0.
  - Reset asserted mid-operation aborts the operation. No result is produced and nothing resumes.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture op, a and b, clear the accumulator, load counter=WIDTH.
  - Go to RUN, or go to DONE directly when op=1 and b=0.
- RUN:
  - in_ready=0; one iteration per cycle; counter decrements.
  - Go to DONE on the cycle the counter reaches 0. Exactly WIDTH RUN cycles.
- Multiply iteration:
  - If multiplier LSB=1, add multiplicand to the upper half of the accumulator, with WIDTH+1-bit add so the carry is kept.
  - Then shift {carry, acc} right by 1.
  - Final value = a*b, exact, with no overflow possible in 2*WIDTH bits.
- Divide iteration:
  - Shift {rem, dividend} left by 1, then compute trial = rem - b in WIDTH+1 bits.
  - If trial is non-negative: rem=trial and quotient bit=1.
  - Otherwise rem is unchanged and quotient bit=0.
- Divide by zero:
  - No iteration is performed.
  - Result has quotient=0 and remainder=a (remainder occupies result[2W-1:W]); div_by_zero=1.
  - Latency is 1 cycle from accept to out_valid.
- DONE:
  - out_valid=1; result and div_by_zero stay stable until out_valid&&out_ready.
  - On that handshake: go to IDLE, out_valid=0 the next cycle, in_ready=1 the next cycle.
  - div_by_zero clears on the next accepted request, not on the DONE exit.
- Latency and throughput:
  - Accept at edge 0; out_valid high after edge WIDTH+1 (normal) or edge 1 (divide by zero).
  - No accept in the same cycle as the result handshake, so minimum spacing is WIDTH+2 cycles per operation.
- in_valid while busy:
  - Ignored; inputs are not sampled.
  - a, b and op may change freely outside the accept cycle.
- out_ready held low: the block stalls in DONE indefinitely with no data loss.
- out_ready=1 on the cycle out_valid first rises: the handshake completes in that cycle.
- Unsigned arithmetic only; no rounding or saturation.

Decomposition:
- Package muldiv_pkg holds:
  - OP_MUL=1'b0 and OP_DIV=1'b1.
  - State enum {IDLE, RUN, DONE}.
- One sub-module is natural: muldiv_step.
  - Combinational single iteration, taking op, acc, operand and divisor and returning next acc.
  - Instantiated once inside muldiv_seq.
  - Lets the bench unit-test one step in isolation.

Test Plan:
- WIDTH=4, multiply a=13, b=11 -> result=0x008F (143), div_by_zero=0, out_valid exactly 5 cycles after accept.
- WIDTH=4, divide a=14, b=3 -> quotient=4 and remainder=2, so result=0x24, div_by_zero=0. Then 15/15 -> result=0x01.
- WIDTH=4, divide a=9, b=0 -> result=0x90, div_by_zero=1, out_valid 1 cycle after accept. Next request 15*15 -> result=0xE1, div_by_zero=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid. Toggle a/b/in_valid during that time -> result stable, in_ready=0. Result handshake on the 7th cycle, in_ready=1 on the following cycle.
- Reset mid-RUN: drop rst_n on the 2nd RUN cycle -> out_valid=0, result=0, in_ready=1 after release. The next operation 3*3 is correct (0x09).
- WIDTH=2 instance: 3*3 -> result=0x9; 3/2 -> result=0x5 (remainder 1, quotient 1); 2/0 -> result=0x8 with div_by_zero=1.
